cle_label_compactor: RTL

Post-labeling stage placed directly downstream of the component labeling engine. Once the engine signals completion, this block walks the 32x32 label image in the shared label SRAM and renumbers every non-zero label to a dense sequence 1..N, in raster order of first occurrence. It then writes the remapped labels back in place and reports the component count. It drives the same single-port SRAM; the top level hands the SRAM port to this block while `busy` is high.

---
 rtl/cle_label_compactor.sv | 112 +++++++++++
 1 files changed

// File: rtl/cle_label_compactor.sv
`default_nettype none
// cle_label_compactor: renumbers the label image in SRAM to dense labels 1..N in raster
// order of first occurrence, writes them back in place and reports the count. Rev 1.0
module cle_label_compactor #(
  parameter int IMG_PIX = 1024,
  parameter int LW      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(IMG_PIX)-1:0] sram_a,
  output logic [LW-1:0]              sram_d,
  output logic                       sram_wen,
  input  logic [LW-1:0]              sram_q,
  output logic [LW-1:0]              comp_cnt,
  output logic                       overflow
);

  localparam int             AW       = $clog2(IMG_PIX);
  localparam int             NLBL     = 1 << LW;
  localparam logic [AW-1:0]  LAST_PIX = AW'(IMG_PIX - 1);
  localparam logic [AW-1:0]  PC_ONE   = AW'(1);
  localparam logic [LW-1:0]  LBL_ONE  = LW'(1);
  localparam logic [LW-1:0]  LBL_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_SCAN_LAST = 3'd2,
    S_RD        = 3'd3,
    S_WR        = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [LW-1:0]   next_lbl;
  logic [NLBL-1:0] valid;
  logic [LW-1:0]   map [NLBL];
  logic            lookup_en;
  logic            alloc;

  // Read data lags the address by one cycle, so the first SCAN cycle has nothing to look up.
  assign lookup_en = ((state == S_SCAN) && (pc != '0)) || (state == S_SCAN_LAST);
  assign alloc     = lookup_en && (sram_q != '0) && !valid[sram_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      next_lbl <= LBL_ONE;
      comp_cnt <= '0;
      overflow <= 1'b0;
      valid    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            valid    <= '0;
            next_lbl <= LBL_ONE;
            comp_cnt <= '0;
            overflow <= 1'b0;
            pc       <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pc == LAST_PIX) state <= S_SCAN_LAST;
          else                pc    <= pc + PC_ONE;
        end
        S_SCAN_LAST: begin
          pc    <= '0;
          state <= S_RD;
        end
        S_RD: state <= S_WR;
        S_WR: begin
          if (pc == LAST_PIX) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + PC_ONE;
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Once the label space is exhausted, later new labels share the top label.
      if (alloc) begin
        valid[sram_q] <= 1'b1;
        if (next_lbl != LBL_MAX) next_lbl <= next_lbl + LBL_ONE;
        if (comp_cnt != LBL_MAX) comp_cnt <= comp_cnt + LBL_ONE;
        else                     overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) map[sram_q] <= next_lbl;
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  // Reset gates the write strobe so an interrupted WR cycle never commits.
  assign sram_wen = !((state == S_WR) && !reset);
  assign sram_a   = ((state == S_SCAN) || (state == S_RD) || (state == S_WR)) ? pc : '0;
  assign sram_d   = ((state == S_WR) && (sram_q != '0)) ? map[sram_q] : '0;

endmodule
`default_nettype wire
